// File: rtl/data_bus_arbiter.sv
// Two-master / one-slave data bus arbiter: latches the granted request, runs one
// strobed access, captures read data and pulses the owner's ack. Macro ARB_RR_EN selects round-robin.
//
// state | meaning
// IDLE  | bus parked at zero, arbitrating between m0_req and m1_req
// ISSUE | one-cycle strobe with latched addr/wdata/wr, wait counter loaded
// WAIT  | address held, counting down ReadLatency cycles to the read sample
// DONE  | owner's ack pulses with rdata valid, last_owner updated
module data_bus_arbiter #(
   parameter int AddrWidth   = 32,
   parameter int DataWidth   = 32,
   parameter int ReadLatency = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 m0_req,
   input  logic [AddrWidth-1:0] m0_addr,
   input  logic [DataWidth-1:0] m0_wdata,
   input  logic                 m0_wr,
   output logic                 m0_ack,
   output logic [DataWidth-1:0] m0_rdata,
   input  logic                 m1_req,
   input  logic [AddrWidth-1:0] m1_addr,
   input  logic [DataWidth-1:0] m1_wdata,
   input  logic                 m1_wr,
   output logic                 m1_ack,
   output logic [DataWidth-1:0] m1_rdata,
   output logic [AddrWidth-1:0] s_addr,
   output logic [DataWidth-1:0] s_wdata,
   output logic                 s_wr,
   output logic                 s_strobe,
   input  logic [DataWidth-1:0] s_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [3:0] WaitLoad = 4'(ReadLatency - 1);

   state_t               state, state_nxt;
   logic                 owner_q, owner_nxt;
   logic                 last_owner_q, last_owner_nxt;
   logic [AddrWidth-1:0] addr_q, addr_nxt;
   logic [DataWidth-1:0] wdata_q, wdata_nxt;
   logic                 wr_q, wr_nxt;
   logic [3:0]           cnt_q, cnt_nxt;
   logic [DataWidth-1:0] m0_rdata_q, m0_rdata_nxt;
   logic [DataWidth-1:0] m1_rdata_q, m1_rdata_nxt;
   logic                 grant_m1;
   logic                 bus_active;

   // grant_m1 = 1 selects m1; only meaningful when at least one req is high
`ifdef ARB_RR_EN
   always_comb begin
      if (m0_req && m1_req) grant_m1 = ~last_owner_q;
      else                  grant_m1 = ~m0_req;
   end
`else
   always_comb begin
      grant_m1 = ~m0_req;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         addr_q       <= '0;
         wdata_q      <= '0;
         wr_q         <= 1'b0;
         cnt_q        <= '0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
      end else begin
         state        <= state_nxt;
         owner_q      <= owner_nxt;
         last_owner_q <= last_owner_nxt;
         addr_q       <= addr_nxt;
         wdata_q      <= wdata_nxt;
         wr_q         <= wr_nxt;
         cnt_q        <= cnt_nxt;
         m0_rdata_q   <= m0_rdata_nxt;
         m1_rdata_q   <= m1_rdata_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner_q;
      last_owner_nxt = last_owner_q;
      addr_nxt       = addr_q;
      wdata_nxt      = wdata_q;
      wr_nxt         = wr_q;
      cnt_nxt        = cnt_q;
      m0_rdata_nxt   = m0_rdata_q;
      m1_rdata_nxt   = m1_rdata_q;
      case (state)
         IDLE: begin
            if (m0_req || m1_req) begin
               owner_nxt = grant_m1;
               addr_nxt  = grant_m1 ? m1_addr  : m0_addr;
               wdata_nxt = grant_m1 ? m1_wdata : m0_wdata;
               wr_nxt    = grant_m1 ? m1_wr    : m0_wr;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            cnt_nxt   = WaitLoad;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               // writes leave the owner's read data register untouched
               if (!wr_q) begin
                  if (owner_q) m1_rdata_nxt = s_rdata;
                  else         m0_rdata_nxt = s_rdata;
               end
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt_q - 4'd1;
            end
         end
         DONE: begin
            last_owner_nxt = owner_q;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus_active = (state == ISSUE) || (state == WAIT);
   assign s_addr     = bus_active ? addr_q  : '0;
   assign s_wdata    = bus_active ? wdata_q : '0;
   assign s_strobe   = (state == ISSUE);
   assign s_wr       = (state == ISSUE) && wr_q;
   assign m0_ack     = (state == DONE) && !owner_q;
   assign m1_ack     = (state == DONE) && owner_q;
   assign m0_rdata   = m0_rdata_q;
   assign m1_rdata   = m1_rdata_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter: a cycle-arithmetic reference model queues
// expected bus and ack activity; a negedge monitor compares against the DUT.
module tb_data_bus_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int RL = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req [2];
   logic [AW-1:0] addr [2];
   logic [DW-1:0] wdata [2];
   logic          wr [2];
   logic          m0_req, m1_req, m0_wr, m1_wr, m0_ack, m1_ack;
   logic [AW-1:0] m0_addr, m1_addr, s_addr;
   logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
   logic          s_wr, s_strobe;

   assign m0_req = req[0];   assign m1_req = req[1];
   assign m0_addr = addr[0]; assign m1_addr = addr[1];
   assign m0_wdata = wdata[0]; assign m1_wdata = wdata[1];
   assign m0_wr = wr[0];     assign m1_wr = wr[1];

   data_bus_arbiter #(.AddrWidth(AW), .DataWidth(DW), .ReadLatency(RL)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wr(m0_wr),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wr(m1_wr),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_wr(s_wr), .s_strobe(s_strobe),
      .s_rdata(s_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            owner;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          wr;
      int            issue;
   } bus_t;
   typedef struct {
      int            owner;
      logic [DW-1:0] rdata;
      logic          wr;
      int            at;
   } ack_t;

   bus_t          bus_q [$];
   ack_t          ack_q [$];
   int            cyc = 0;
   int            n_cmp = 0;
   int            n_err = 0;
   bit            chk_en = 1'b0;
   logic [DW-1:0] rd_tab [0:8191];
   logic [DW-1:0] model_rd [2];
   bit            busy [2];
   int            done_at [2];
   int            free_at;
   int            last_owner;
   logic [1:0]    force_mask;
   logic [AW-1:0] d_addr [2];
   logic [DW-1:0] d_wdata [2];
   logic          d_wr [2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      bus_q.delete();
      ack_q.delete();
      for (int m = 0; m < 2; m++) begin
         req[m] = 1'b0; busy[m] = 1'b0; done_at[m] = 0; model_rd[m] = '0;
      end
      free_at = 0;
      last_owner = 1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_m0_ack"}, 64'(m0_ack), 64'd0);
      chk({tag, "_m1_ack"}, 64'(m1_ack), 64'd0);
      chk({tag, "_m0_rdata"}, 64'(m0_rdata), 64'd0);
      chk({tag, "_m1_rdata"}, 64'(m1_rdata), 64'd0);
      chk({tag, "_s_addr"}, 64'(s_addr), 64'd0);
      chk({tag, "_s_wdata"}, 64'(s_wdata), 64'd0);
      chk({tag, "_s_wr"}, 64'(s_wr), 64'd0);
      chk({tag, "_s_strobe"}, 64'(s_strobe), 64'd0);
   endtask

   // One clock: master behaviour, then the reference arbitration for this cycle.
   task automatic step(input int pct);
      @(posedge clk);
      #1;
      s_rdata = rd_tab[cyc % 8192];
      for (int m = 0; m < 2; m++) begin
         if (busy[m] && cyc == done_at[m] + 1) begin
            busy[m] = 1'b0;
            req[m]  = 1'b0;
         end
         if (busy[m] && $urandom_range(0, 7) == 0) begin
            addr[m]  = $urandom;
            wdata[m] = $urandom;
            wr[m]    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) req[m] = 1'b0;
         end
         if (!busy[m] && !req[m]) begin
            if (force_mask[m]) begin
               req[m] = 1'b1; addr[m] = d_addr[m]; wdata[m] = d_wdata[m]; wr[m] = d_wr[m];
            end else if (int'($urandom_range(0, 99)) < pct) begin
               req[m] = 1'b1; addr[m] = $urandom; wdata[m] = $urandom;
               wr[m] = 1'($urandom_range(0, 1));
            end
         end
      end
      if (cyc >= free_at && (req[0] || req[1])) begin
         int   g;
         bus_t b;
         ack_t a;
`ifdef ARB_RR_EN
         if (req[0] && req[1]) g = 1 - last_owner;
         else                  g = req[0] ? 0 : 1;
`else
         g = req[0] ? 0 : 1;
`endif
         b.owner = g; b.addr = addr[g]; b.wdata = wdata[g]; b.wr = wr[g]; b.issue = cyc + 1;
         a.owner = g; a.wr = wr[g]; a.at = cyc + RL + 2;
         a.rdata = rd_tab[(cyc + 1 + RL) % 8192];
         bus_q.push_back(b);
         ack_q.push_back(a);
         busy[g]    = 1'b1;
         done_at[g] = cyc + RL + 2;
         free_at    = cyc + RL + 3;
         last_owner = g;
      end
   endtask

   always @(negedge clk) begin
      logic [AW-1:0] ea;
      logic [DW-1:0] ew;
      logic          es, ewr, ea0, ea1;
      if (chk_en && rst_n) begin
         ea = '0; ew = '0; es = 1'b0; ewr = 1'b0; ea0 = 1'b0; ea1 = 1'b0;
         if (bus_q.size() > 0 && cyc >= bus_q[0].issue) begin
            ea  = bus_q[0].addr;
            ew  = bus_q[0].wdata;
            es  = (cyc == bus_q[0].issue);
            ewr = es && bus_q[0].wr;
         end
         chk("s_addr", 64'(s_addr), 64'(ea));
         chk("s_wdata", 64'(s_wdata), 64'(ew));
         chk("s_strobe", 64'(s_strobe), 64'(es));
         chk("s_wr", 64'(s_wr), 64'(ewr));
         if (bus_q.size() > 0 && cyc >= bus_q[0].issue + RL) void'(bus_q.pop_front());
         if (ack_q.size() > 0 && cyc == ack_q[0].at) begin
            if (ack_q[0].owner == 0) ea0 = 1'b1; else ea1 = 1'b1;
            if (!ack_q[0].wr) model_rd[ack_q[0].owner] = ack_q[0].rdata;
            void'(ack_q.pop_front());
         end
         chk("m0_ack", 64'(m0_ack), 64'(ea0));
         chk("m1_ack", 64'(m1_ack), 64'(ea1));
         chk("m0_rdata", 64'(m0_rdata), 64'(model_rd[0]));
         chk("m1_rdata", 64'(m1_rdata), 64'(model_rd[1]));
      end
   end

   initial begin
      int  k;
      bit  hit;
      for (int i = 0; i < 8192; i++) rd_tab[i] = $urandom;
      for (int m = 0; m < 2; m++) begin
         addr[m] = '0; wdata[m] = '0; wr[m] = 1'b0; d_addr[m] = '0; d_wdata[m] = '0; d_wr[m] = 1'b0;
      end
      s_rdata = '0;
      force_mask = 2'b00;
      model_reset();
      rst_n = 1'b0;
      repeat (3) step(0);
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk_en = 1'b1;

      // directed: m0 read at 0x100, then m1 write 0x41 to 0x2000_0004
      d_addr[0] = 32'h100; d_wdata[0] = '0; d_wr[0] = 1'b0;
      force_mask = 2'b01; step(0); force_mask = 2'b00;
      repeat (RL + 4) step(0);
      d_addr[1] = 32'h2000_0004; d_wdata[1] = 32'h41; d_wr[1] = 1'b1;
      force_mask = 2'b10; step(0); force_mask = 2'b00;
      repeat (RL + 4) step(0);

      // both masters requesting continuously
      repeat (4 * (RL + 3) + 2) step(100);
      repeat (1500) step(30);

      // reset pulled during WAIT
      hit = 1'b0;
      for (k = 0; k < 300 && !hit; k++) begin
         step(40);
         hit = (bus_q.size() > 0 && cyc > bus_q[0].issue && cyc <= bus_q[0].issue + RL);
      end
      chk("reset_wait_found", 64'(hit), 64'd1);
      chk_en = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk_all_zero("midrst");
      model_reset();
      repeat (2) step(0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk_en = 1'b1;

      // first tie after reset must go to m0
      d_addr[0] = $urandom; d_wdata[0] = $urandom; d_wr[0] = 1'b0;
      d_addr[1] = $urandom; d_wdata[1] = $urandom; d_wr[1] = 1'b1;
      force_mask = 2'b11; step(0); force_mask = 2'b00;
      repeat (600) step(30);

      for (k = 0; k < 500; k++) begin
         if (bus_q.size() == 0 && ack_q.size() == 0 && !req[0] && !req[1] && !busy[0] && !busy[1]) break;
         step(0);
      end
      chk("drain_bus_q", 64'(bus_q.size()), 64'd0);
      chk("drain_ack_q", 64'(ack_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the shared data bus.
- Lets the CPU data port (m0) and a second requester (m1, e.g. a DMA or debug loader) share the address-decoded RAM/UART bus.
- Latches the winning request, drives it to the bus for a fixed number of cycles, captures read data, and returns a one-cycle ack to the owner.
- Sits between the masters and the address decoder / RAM / UART fan-out.

Parameters:
- AddrWidth, 32, width of master and slave address buses.
- DataWidth, 32, width of write and read data buses.
- ReadLatency, 1, cycles from the strobe cycle to valid s_rdata. Legal range 1..15.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- m0_req, m1_req  input  1  request; held high until the matching ack.
- m0_addr, m1_addr  input  AddrWidth  request address.
- m0_wdata, m1_wdata  input  DataWidth  write data.
- m0_wr, m1_wr  input  1  1 = write, 0 = read.
- m0_ack, m1_ack  output  1  one-cycle completion pulse.
- m0_rdata, m1_rdata  output  DataWidth  captured read data; valid while the corresponding ack=1, held until the next completion for that master.
- s_addr  output  AddrWidth  bus address.
- s_wdata  output  DataWidth  bus write data.
- s_wr  output  1  bus write enable.
- s_strobe  output  1  one-cycle access strobe.
- s_rdata  input  DataWidth  bus read data.

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE.
  - All outputs 0: acks, rdata, s_addr, s_wdata, s_wr, s_strobe.
  - last_owner=1, so m0 wins the first tie.
- FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - If any req is high, pick the owner and register owner, addr, wdata, wr at the edge, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - s_strobe=1.
  - s_addr, s_wdata from the latch.
  - s_wr = latched wr.
  - Load wait counter = ReadLatency-1, then go to WAIT.
- WAIT (ReadLatency cycles):
  - s_addr and s_wdata stay driven from the latch; s_strobe=0, s_wr=0.
  - Counter decrements each cycle.
  - On the cycle with counter=0: capture s_rdata into the owner's rdata register (reads only; writes leave rdata unchanged), then go to DONE.
- DONE (1 cycle):
  - Owner's ack=1 and owner's rdata is valid.
  - Update last_owner to the owner, then go to IDLE.
- Bus idle value: outside ISSUE/WAIT, s_addr=0, s_wdata=0, s_wr=0, s_strobe=0.
- Latency:
  - A request seen in IDLE cycle t gives ack in cycle t+ReadLatency+2.
  - The next arbitration is in cycle t+ReadLatency+3.
  - Minimum spacing between accesses is ReadLatency+3 cycles.
- Masters see ack at the edge ending DONE. req sampled in the following IDLE cycle counts as a new request.
- Arbitration: round-robin. When both req are high in IDLE, grant the master that is not last_owner. A single requester always wins.
- Request dropped or changed mid-transaction: ignored. The latched transaction completes and ack still pulses.
- Reset asserted mid-transaction: immediate return to reset values; no ack issued; the slave strobe is aborted.
- ack is never high for both masters in the same cycle. At most one ack per granted transaction.
- m*_wdata and m*_addr are sampled only on the grant edge.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration as described above.
- Undefined: fixed priority; m0 wins whenever m0_req=1 in IDLE. last_owner is still maintained but does not affect grants. m1 may starve.

Test Plan:
- m0 read, ReadLatency=1, addr 0x100, s_rdata=0xDEADBEEF driven in the WAIT cycle -> s_strobe high 1 cycle at t+1 with s_addr=0x100, s_wr=0; m0_ack at t+3 with m0_rdata=0xDEADBEEF; m1_ack stays 0.
- m1 write addr 0x2000_0004, wdata 0x41 -> ISSUE cycle has s_wr=1, s_strobe=1, s_wdata=0x41; s_wr is 0 in WAIT; m1_ack at t+3; m1_rdata unchanged.
- Both req held high continuously for 4 transactions (ARB_RR_EN defined) -> grant order m0, m1, m0, m1, one ack every 4 cycles; same test with macro undefined -> m0 granted all 4.
- ReadLatency=3 -> WAIT lasts 3 cycles, ack at t+5, s_rdata captured from the third WAIT cycle only.
- m0 drops req and changes addr during WAIT -> transaction completes with the original address and m0_ack still pulses.
- rst_n pulled low during WAIT -> all outputs 0 asynchronously; no ack; after release the FSM is in IDLE and the first tie goes to m0.
